hybrid_addsub_pipe: RTL



---
 rtl/hybrid_addsub_pipe.sv | 129 ++++++++++++
 1 files changed

// File: rtl/hybrid_addsub_pipe.sv
// Carry-pipelined add/subtract unit with valid/ready handshake; the carry chain is split into STAGES chunks.
// Optional signed saturation of the result is enabled by defining HYBRID_ADDER_SAT_EN.
module hybrid_addsub_pipe #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int unsigned C = WIDTH / STAGES;

  logic [WIDTH-1:0] b_eff;

  assign b_eff    = in_sub ? ~in_b : in_b;
  // The whole pipe, bubbles included, shifts only when the output slot is free or draining.
  assign in_ready = !out_valid || out_ready;

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    logic [C-1:0]       a_chk;
    logic [C-1:0]       b_chk;
    logic               cin;
    logic               valid_d;
    logic [C:0]         add_c;
    logic [(k+1)*C-1:0] sum_raw;
    logic [(k+1)*C-1:0] sum_d;
    logic               valid_q;
    logic               cout_q;
    logic [(k+1)*C-1:0] sum_q;

    if (k == 0) begin : g_src
      assign a_chk   = in_a[C-1:0];
      assign b_chk   = b_eff[C-1:0];
      assign cin     = in_sub;
      assign valid_d = in_valid;
      assign sum_raw = add_c[C-1:0];
    end else begin : g_src
      assign a_chk   = g_stg[k-1].g_skew.a_rem[C-1:0];
      assign b_chk   = g_stg[k-1].g_skew.b_rem[C-1:0];
      assign cin     = g_stg[k-1].cout_q;
      assign valid_d = g_stg[k-1].valid_q;
      assign sum_raw = {add_c[C-1:0], g_stg[k-1].sum_q};
    end

    assign add_c = {1'b0, a_chk} + {1'b0, b_chk} + (C+1)'(cin);

    // Skew: operand chunks not yet consumed ride along until their stage.
    if (k < STAGES - 1) begin : g_skew
      localparam int unsigned RW = WIDTH - (k + 1) * C;
      logic [RW-1:0] a_rem;
      logic [RW-1:0] b_rem;
      logic [RW-1:0] a_rem_d;
      logic [RW-1:0] b_rem_d;

      if (k == 0) begin : g_from_in
        assign a_rem_d = in_a[WIDTH-1:C];
        assign b_rem_d = b_eff[WIDTH-1:C];
      end else begin : g_from_prev
        assign a_rem_d = g_stg[k-1].g_skew.a_rem[RW+C-1:C];
        assign b_rem_d = g_stg[k-1].g_skew.b_rem[RW+C-1:C];
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          a_rem <= '0;
          b_rem <= '0;
        end else if (in_ready) begin
          a_rem <= a_rem_d;
          b_rem <= b_rem_d;
        end
      end
    end

    if (k == STAGES - 1) begin : g_out
      logic ovf_c;
      logic ovf_q;

      // Carry into the MSB recovered as a^b^sum at that bit.
      assign ovf_c = a_chk[C-1] ^ b_chk[C-1] ^ add_c[C-1] ^ add_c[C];

`ifdef HYBRID_ADDER_SAT_EN
      // On overflow the true sign is the operands' common sign, i.e. A's MSB.
      assign sum_d = !ovf_c       ? sum_raw :
                     a_chk[C-1]   ? {1'b1, (WIDTH-1)'(0)} :
                                    {1'b0, {(WIDTH-1){1'b1}}};
`else
      assign sum_d = sum_raw;
`endif

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else if (in_ready) begin
          ovf_q <= ovf_c;
        end
      end
    end else begin : g_mid
      assign sum_d = sum_raw;
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
        cout_q  <= 1'b0;
        sum_q   <= '0;
      end else if (in_ready) begin
        valid_q <= valid_d;
        cout_q  <= add_c[C];
        sum_q   <= sum_d;
      end
    end
  end

  assign out_valid = g_stg[STAGES-1].valid_q;
  assign out_sum   = g_stg[STAGES-1].sum_q;
  assign out_cout  = g_stg[STAGES-1].cout_q;
  assign out_ovf   = g_stg[STAGES-1].g_out.ovf_q;

endmodule
